fir_param: RTL and testbench



---
 rtl/fir_pkg.sv | 19 +
 rtl/fir_out_quant.sv | 45 ++++
 rtl/fir_param.sv | 89 ++++++++
 tb/tb_fir_param.sv | 333 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fir_pkg.sv
// Shared constants and width helpers for the FIR filter family.
package fir_pkg;

  localparam int NB_DEF    = 14;
  localparam int ORDER_DEF = 10;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  // Full-precision accumulator width for n products of two nb-bit values.
  function automatic int acc_w(input int nb, input int n);
    return 2 * nb + clog2(n);
  endfunction

endpackage

// File: rtl/fir_out_quant.sv
// Output quantiser: floor shift by NB-1, saturate or wrap, then register.
module fir_out_quant #(
  parameter int NB  = 14,
  parameter int AW  = 32,
  parameter int SAT = 1
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_v,
  input  logic [AW-1:0] i_acc,
  output logic [NB-1:0] o_dout,
  output logic          o_vout
);

  localparam logic signed [AW-1:0] MAXV =
    AW'((64'sd1 <<< (NB - 1)) - 64'sd1);
  localparam logic signed [AW-1:0] MINV = ~MAXV;

  logic signed [AW-1:0] w_sh;
  logic [NB-1:0]        w_q;

  assign w_sh = $signed(i_acc) >>> (NB - 1);

  always_comb begin
    w_q = w_sh[NB-1:0];
    if (SAT != 0) begin
      if (w_sh > MAXV)
        w_q = MAXV[NB-1:0];
      else if (w_sh < MINV)
        w_q = MINV[NB-1:0];
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      o_dout <= '0;
      o_vout <= 1'b0;
    end else begin
      o_vout <= i_v;
      if (i_v)
        o_dout <= w_q;
    end
  end

endmodule

// File: rtl/fir_param.sv
// Parametrised direct-form FIR: tap line, multipliers, adder tree,
// optional accumulator pipeline and a matching valid pipeline.
module fir_param
  import fir_pkg::*;
#(
  parameter int NB    = NB_DEF,
  parameter int ORDER = ORDER_DEF,
  parameter int PIPE  = 0,
  parameter int SAT   = 1
) (
  input  logic                    CLK,
  input  logic                    RST_n,
  input  logic [NB-1:0]           DIN,
  input  logic                    VIN,
  input  logic [(ORDER+1)*NB-1:0] B,
  output logic [NB-1:0]           DOUT,
  output logic                    VOUT
);

  localparam int N  = ORDER + 1;
  localparam int AW = acc_w(NB, N);

  logic signed [NB-1:0]   r_x [N];
  logic                   r_v0;
  logic signed [2*NB-1:0] w_prod [N];
  logic signed [AW-1:0]   w_acc;
  logic signed [AW-1:0]   w_a [PIPE+1];
  logic [PIPE:0]          w_v;

  always_ff @(posedge CLK) begin
    if (!RST_n) begin
      for (int i = 0; i < N; i++)
        r_x[i] <= '0;
      r_v0 <= 1'b0;
    end else begin
      r_v0 <= VIN;
      if (VIN) begin
        r_x[0] <= DIN;
        for (int i = 1; i < N; i++)
          r_x[i] <= r_x[i-1];
      end
    end
  end

  for (genvar i = 0; i < N; i++) begin : g_tap
    assign w_prod[i] =
      (2*NB)'($signed(B[i*NB +: NB])) * (2*NB)'(r_x[i]);
  end

  always_comb begin
    w_acc = '0;
    for (int i = 0; i < N; i++)
      w_acc = w_acc + AW'(w_prod[i]);
  end

  assign w_a[0] = w_acc;
  assign w_v[0] = r_v0;

  // Each extra stage delays the sum and its valid bit together.
  for (genvar k = 1; k <= PIPE; k++) begin : g_pipe
    logic signed [AW-1:0] r_a;
    logic                 r_v;
    always_ff @(posedge CLK) begin
      if (!RST_n) begin
        r_a <= '0;
        r_v <= 1'b0;
      end else begin
        r_a <= w_a[k-1];
        r_v <= w_v[k-1];
      end
    end
    assign w_a[k] = r_a;
    assign w_v[k] = r_v;
  end

  fir_out_quant #(
    .NB  (NB),
    .AW  (AW),
    .SAT (SAT)
  ) u_quant (
    .i_clk   (CLK),
    .i_rst_n (RST_n),
    .i_v     (w_v[PIPE]),
    .i_acc   (w_a[PIPE]),
    .o_dout  (DOUT),
    .o_vout  (VOUT)
  );

endmodule

// File: tb/tb_fir_param.sv
// Directed vector table, mid-flight reset sequence and a
// random sweep against a longint golden model.
module tb_fir_param;

  localparam int NT = 11;

  logic clk;
  logic rst_n;

  logic [13:0]      din14;
  logic             vin14;
  logic [NT*14-1:0] b14;
  logic [13:0]      d0, d1, d2;
  logic             v0, v1, v2;

  logic [7:0]   din3;
  logic         vin3;
  logic [31:0]  b3;
  logic [7:0]   d3;
  logic         v3;

  logic [15:0]  din4;
  logic         vin4;
  logic [511:0] b4;
  logic [15:0]  d4;
  logic         v4;

  fir_param #(.NB(14), .ORDER(10), .PIPE(0), .SAT(1)) u0 (
    .CLK(clk), .RST_n(rst_n), .DIN(din14), .VIN(vin14),
    .B(b14), .DOUT(d0), .VOUT(v0));

  fir_param #(.NB(14), .ORDER(10), .PIPE(0), .SAT(0)) u1 (
    .CLK(clk), .RST_n(rst_n), .DIN(din14), .VIN(vin14),
    .B(b14), .DOUT(d1), .VOUT(v1));

  fir_param #(.NB(14), .ORDER(10), .PIPE(2), .SAT(1)) u2 (
    .CLK(clk), .RST_n(rst_n), .DIN(din14), .VIN(vin14),
    .B(b14), .DOUT(d2), .VOUT(v2));

  fir_param #(.NB(8), .ORDER(3), .PIPE(0), .SAT(1)) u3 (
    .CLK(clk), .RST_n(rst_n), .DIN(din3), .VIN(vin3),
    .B(b3), .DOUT(d3), .VOUT(v3));

  fir_param #(.NB(16), .ORDER(31), .PIPE(4), .SAT(0)) u4 (
    .CLK(clk), .RST_n(rst_n), .DIN(din4), .VIN(vin4),
    .B(b4), .DOUT(d4), .VOUT(v4));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit rst_n;
    bit vin;
    int din;
    int bc;
    bit chk;
    bit vout;
    int dout;
    int dout_w;
  } vec_t;

  typedef struct {
    longint val;
    int     due;
  } exp_t;

  vec_t   tbl[$];
  exp_t   q3[$];
  exp_t   q4[$];
  longint mx[2][64];
  longint mb[2][64];
  int     npass = 0;
  int     nchk  = 0;
  int     cyc   = 0;

  function automatic int cnb(input int s);
    return (s == 0) ? 8 : 16;
  endfunction

  function automatic int cnt(input int s);
    return (s == 0) ? 4 : 32;
  endfunction

  function automatic int cpipe(input int s);
    return (s == 0) ? 0 : 4;
  endfunction

  function automatic bit csat(input int s);
    return (s == 0);
  endfunction

  function automatic longint gold(input int s);
    longint acc, y, full, half;
    int nb;
    nb   = cnb(s);
    full = 64'sd1 <<< nb;
    half = full >>> 1;
    acc  = 0;
    for (int i = 0; i < cnt(s); i++)
      acc += mb[s][i] * mx[s][i];
    y = acc >>> (nb - 1);
    if (csat(s)) begin
      if (y > half - 1)
        y = half - 1;
      else if (y < -half)
        y = -half;
    end else begin
      y = y & (full - 1);
      if (y >= half)
        y -= full;
    end
    return y;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic cmp(input string nm, input int idx,
                     input longint got, input longint exp);
    nchk++;
    if (got == exp)
      npass++;
    else
      $display("FAIL %s @%0d: got %0d, expected %0d",
               nm, idx, got, exp);
  endtask

  task automatic add(input bit r, input bit v, input int d,
                     input int bc, input bit c, input bit vo,
                     input int dq, input int dw);
    vec_t e;
    e.rst_n  = r;
    e.vin    = v;
    e.din    = d;
    e.bc     = bc;
    e.chk    = c;
    e.vout   = vo;
    e.dout   = dq;
    e.dout_w = dw;
    tbl.push_back(e);
  endtask

  task automatic rnd_val(input int s, input int shmax, output longint c);
    longint full, half;
    int r;
    full = 64'sd1 <<< cnb(s);
    half = full >>> 1;
    r = int'($urandom_range(0, 65535));
    c = longint'(r) & (full - 1);
    if (c >= half)
      c -= full;
    c = c >>> $urandom_range(0, shmax);
  endtask

  task automatic set_b(input int s);
    longint c;
    for (int i = 0; i < cnt(s); i++) begin
      rnd_val(s, 4, c);
      mb[s][i] = c;
      if (s == 0)
        b3[i*8 +: 8] = c[7:0];
      else
        b4[i*16 +: 16] = c[15:0];
    end
  endtask

  task automatic push(input int s, input longint d);
    exp_t e;
    for (int i = cnt(s) - 1; i > 0; i--)
      mx[s][i] = mx[s][i-1];
    mx[s][0] = d;
    e.val = gold(s);
    e.due = cyc + 2 + cpipe(s);
    if (s == 0)
      q3.push_back(e);
    else
      q4.push_back(e);
  endtask

  task automatic chk_sb(input int s, input bit vout, input longint got);
    exp_t e;
    bit   have;
    have = (s == 0) ? (q3.size() > 0) : (q4.size() > 0);
    e.val = 0;
    e.due = -1;
    if (have)
      e = (s == 0) ? q3[0] : q4[0];
    if (vout || (have && e.due == cyc)) begin
      nchk++;
      if (vout && have && e.due == cyc && e.val == got)
        npass++;
      else
        $display("FAIL sweep%0d @%0d: vout=%0d dout=%0d, expected vout=1 at %0d dout=%0d",
                 s, cyc, vout, got, e.due, e.val);
      if (have) begin
        if (s == 0)
          void'(q3.pop_front());
        else
          void'(q4.pop_front());
      end
    end
  endtask

  initial begin
    logic [13:0] bb;
    longint      d;
    int          ns0, ns1, m, e;
    bit          a3, a4;

    rst_n = 1'b0;
    vin14 = 1'b0; din14 = '0; b14 = '0;
    vin3  = 1'b0; din3  = '0; b3  = '0;
    vin4  = 1'b0; din4  = '0; b4  = '0;
    for (int s = 0; s < 2; s++)
      for (int i = 0; i < 64; i++) begin
        mx[s][i] = 0;
        mb[s][i] = 0;
      end

    for (int k = 0; k < 3; k++)
      add(0, 1, 8191, 4096, 1, 0, 0, 0);
    add(1, 1, 8191, 4096, 1, 0, 0, 0);
    for (int k = 1; k <= 14; k++)
      add(1, 1, 0, 4096, 1, 1, (k <= 11) ? 4095 : 0, (k <= 11) ? 4095 : 0);
    add(1, 0, 0, 4096, 1, 1, 0, 0);
    for (int j = 0; j < 26; j++) begin
      e = 0;
      if (j > 0) begin
        m = (j % 2 == 1) ? (j - 1) / 2 : (j - 2) / 2;
        e = (m <= 10) ? 4095 : 0;
      end
      add(1, (j % 2 == 0), (j == 0) ? 8191 : 0, 4096, 1, (j % 2 == 1), e, e);
    end
    for (int k = 0; k < 11; k++)
      add(1, 1, 8191, 8191, (k == 1), 1, 8190, 8190);
    add(1, 0, 0, 8191, 1, 1, 8191, 8170);
    for (int k = 0; k < 11; k++)
      add(1, 1, -8192, 8191, 0, 0, 0, 0);
    add(1, 0, 0, 8191, 1, 1, -8192, -8181);
    add(1, 0, 0, 8191, 1, 0, -8192, -8181);

    foreach (tbl[i]) begin
      rst_n = tbl[i].rst_n;
      vin14 = tbl[i].vin;
      din14 = 14'(tbl[i].din);
      bb    = 14'(tbl[i].bc);
      b14   = {NT{bb}};
      tick();
      if (tbl[i].chk) begin
        cmp("u0_vout", i, longint'(v0), longint'(tbl[i].vout));
        cmp("u0_dout", i, longint'($signed(d0)), longint'(tbl[i].dout));
        cmp("u1_vout", i, longint'(v1), longint'(tbl[i].vout));
        cmp("u1_dout", i, longint'($signed(d1)), longint'(tbl[i].dout_w));
      end
    end

    b14 = '0;
    b14[13:0] = 14'd8191;
    rst_n = 1'b1;
    vin14 = 1'b1;
    din14 = 14'd500; tick();
    din14 = 14'd600; tick();
    din14 = 14'd700; tick();
    vin14 = 1'b0;
    rst_n = 1'b0;
    tick();
    cmp("mr_rst_vout", 0, longint'(v2), 0);
    cmp("mr_rst_dout", 0, longint'($signed(d2)), 0);
    rst_n = 1'b1;
    vin14 = 1'b1;
    din14 = 14'd100;
    tick();
    cmp("mr_vout_e5", 1, longint'(v2), 0);
    cmp("mr_u0_vout_e5", 1, longint'(v0), 0);
    vin14 = 1'b0;
    tick();
    cmp("mr_vout_e6", 2, longint'(v2), 0);
    cmp("mr_u0_vout_e6", 2, longint'(v0), 1);
    cmp("mr_u0_dout_e6", 2, longint'($signed(d0)), 99);
    tick();
    cmp("mr_vout_e7", 3, longint'(v2), 0);
    tick();
    cmp("mr_vout_e8", 4, longint'(v2), 1);
    cmp("mr_dout_e8", 4, longint'($signed(d2)), 99);
    tick();
    cmp("mr_vout_e9", 5, longint'(v2), 0);
    cmp("mr_hold_e9", 5, longint'($signed(d2)), 99);

    for (int seg = 0; seg < 2; seg++) begin
      set_b(0);
      set_b(1);
      ns0 = 0;
      ns1 = 0;
      while (ns0 < 5000 || ns1 < 5000) begin
        a3 = (ns0 < 5000) && ($urandom_range(0, 3) != 0);
        a4 = (ns1 < 5000) && ($urandom_range(0, 3) != 0);
        rnd_val(0, 0, d);
        din3 = d[7:0];
        if (a3) begin
          push(0, d);
          ns0++;
        end
        rnd_val(1, 0, d);
        din4 = d[15:0];
        if (a4) begin
          push(1, d);
          ns1++;
        end
        vin3 = a3;
        vin4 = a4;
        tick();
        chk_sb(0, v3, longint'($signed(d3)));
        chk_sb(1, v4, longint'($signed(d4)));
      end
      vin3 = 1'b0;
      vin4 = 1'b0;
      for (int k = 0; k < 10; k++) begin
        tick();
        chk_sb(0, v3, longint'($signed(d3)));
        chk_sb(1, v4, longint'($signed(d4)));
      end
      cmp("sweep0_drain", seg, longint'(q3.size()), 0);
      cmp("sweep1_drain", seg, longint'(q4.size()), 0);
    end

    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

endmodule
